// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, the NOP
// encoding used for bubbles and flushes, and the PCsrc redirect codes that the
// decode-stage control unit drives.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    localparam logic [1:0]  PCSRC_SEQ  = 2'b00;
    localparam logic [1:0]  PCSRC_BR   = 2'b01;
    localparam logic [1:0]  PCSRC_JALR = 2'b10;

    // JALR targets always have bit 0 cleared before they reach the PC.
    function automatic logic [31:0] jalr_align(input logic [31:0] tgt);
        return {tgt[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fd_reg.sv
// F/D pipeline register. A flush loads a NOP bubble, a load captures a new
// instruction with its PC, a stall holds the current contents, and any other
// cycle loads a bubble. PC fields are left untouched by bubbles.
module fetch_fd_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_in,
    input  logic        load_in,
    input  logic        stall_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pcplus4_out,
    output logic        valid_out
);

    logic [31:0] instr_d, instr_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] pcplus4_d, pcplus4_q;
    logic        valid_d, valid_q;

    // Next contents: flush beats load, load beats stall-hold, otherwise bubble.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (flush_in) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_in) begin
            instr_d   = instr_in;
            pc_d      = pc_in;
            pcplus4_d = pc_in + 32'd4;
            valid_d   = 1'b1;
        end else if (!stall_in) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    // Register update with asynchronous return to the reset bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= 32'd0;
            pcplus4_q <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign pcplus4_out = pcplus4_q;
    assign valid_out   = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction-memory
// request in flight, applies decode-stage redirects and feeds the F/D register.
// Optional statistics counters are built only when FETCH_STATS_EN is defined;
// otherwise FetchCount_out and RedirectCount_out are tied to zero.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PCsrc_in,
    input  logic [31:0] PCTarget_in,
    input  logic [31:0] ALUResult_in,
    input  logic        StallD_in,
    output logic [31:0] ImemAddr_out,
    output logic        ImemReq_out,
    input  logic [31:0] ImemRdata_in,
    input  logic        ImemValid_in,
    output logic [31:0] InstrD_out,
    output logic [31:0] PCD_out,
    output logic [31:0] PCPlus4D_out,
    output logic        ValidD_out,
    output logic [31:0] FetchCount_out,
    output logic [31:0] RedirectCount_out
);

    fetch_state_t state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic         req_d, req_q;
    logic [31:0]  hold_d, hold_q;
    logic         redirect;
    logic [31:0]  redirect_tgt;
    logic         deliver;
    logic [31:0]  deliver_instr;

    // Decode the redirect code; the reserved encoding behaves as sequential.
    always_comb begin
        redirect     = 1'b0;
        redirect_tgt = PCTarget_in;
        case (PCsrc_in)
            PCSRC_BR: begin
                redirect     = 1'b1;
                redirect_tgt = PCTarget_in;
            end
            PCSRC_JALR: begin
                redirect     = 1'b1;
                redirect_tgt = jalr_align(ALUResult_in);
            end
            default: begin
                redirect     = 1'b0;
                redirect_tgt = PCTarget_in;
            end
        endcase
    end

    // Next state, next PC and delivery decision; a redirect overrides everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        deliver       = 1'b0;
        deliver_instr = ImemRdata_in;
        if (redirect) begin
            pc_d = redirect_tgt;
            case (state_q)
                IDLE:    state_d = REQ;
                REQ:     state_d = DROP;
                WAIT:    state_d = ImemValid_in ? REQ : DROP;
                HOLD:    state_d = REQ;
                DROP:    state_d = ImemValid_in ? REQ : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ:  state_d = WAIT;
                WAIT: begin
                    if (ImemValid_in) begin
                        if (!StallD_in) begin
                            deliver       = 1'b1;
                            deliver_instr = ImemRdata_in;
                            pc_d          = pc_q + 32'd4;
                            state_d       = REQ;
                        end else begin
                            hold_d  = ImemRdata_in;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!StallD_in) begin
                        deliver       = 1'b1;
                        deliver_instr = hold_q;
                        pc_d          = pc_q + 32'd4;
                        state_d       = REQ;
                    end
                end
                DROP: begin
                    if (ImemValid_in) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // The request pulse is registered: it is high for exactly the REQ cycle.
        req_d = (state_d == REQ);
    end

    // FSM, PC and registered request pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
        end
    end

    // Hold register for a word that arrived while decode was stalled.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign ImemAddr_out = pc_q;
    assign ImemReq_out  = req_q;

    fetch_fd_reg u_fd_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_in    (redirect),
        .load_in     (deliver),
        .stall_in    (StallD_in),
        .instr_in    (deliver_instr),
        .pc_in       (pc_q),
        .instr_out   (InstrD_out),
        .pc_out      (PCD_out),
        .pcplus4_out (PCPlus4D_out),
        .valid_out   (ValidD_out)
    );

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_d, fetch_cnt_q;
    logic [31:0] redir_cnt_d, redir_cnt_q;

    // Delivered-instruction and redirect counters, both wrapping at 2^32.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (deliver) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (redirect) begin
            redir_cnt_d = redir_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            redir_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign FetchCount_out    = fetch_cnt_q;
    assign RedirectCount_out = redir_cnt_q;
`else
    assign FetchCount_out    = 32'd0;
    assign RedirectCount_out = 32'd0;
`endif

    // A response is only legal while a request is in flight (WAIT or DROP).
    a_no_stray_valid : assert property (@(posedge clk) disable iff (!rst_n)
        !(ImemValid_in && (state_q == IDLE || state_q == REQ || state_q == HOLD)));

endmodule
